mem_port_arbiter: RTL and testbench

Shares the CPU's single memory port between the IF-stage instruction fetch and the MEM-stage load/store. Each request is granted, sequenced through a configurable number of memory wait states, and acknowledged with a one-cycle ready pulse. Data accesses have priority, and a streak counter bounds how long a fetch can be starved. The block sits between the `CPU` pipeline and the `Memory` model and replaces their direct combinational connection.

---
 rtl/cpu_mem_pkg.sv | 20 ++
 rtl/mem_arb_select.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the CPU memory-port arbiter.
// Imported by the arbiter top level.
package cpu_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W      = 3;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

endpackage

// File: rtl/mem_arb_select.sv
// Grant decision between fetch and data requests.
// Data wins unless a fetch has waited through MAX_DATA_STREAK data grants.
module mem_arb_select #(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic d_req,
    input  logic grant_en,
    output logic grant_d,
    output logic grant_if
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    logic [SW-1:0] streak;
    logic          d_ok;

    assign d_ok     = !if_req || (streak < STREAK_MAX);
    assign grant_d  = grant_en && d_req && d_ok;
    assign grant_if = grant_en && if_req && !grant_d;

    // Streak only counts data grants that actually held off a fetch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak <= '0;
        end else if (grant_d) begin
            if (!if_req) begin
                streak <= '0;
            end else if (streak != STREAK_MAX) begin
                streak <= streak + 1'b1;
            end
        end else if (grant_if) begin
            streak <= '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Each access: grant, WAIT_STATES+1 strobe cycles, one-cycle ready.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int DATA_W          = DATA_W_DEF,
    parameter int WAIT_STATES     = 1,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state;
    arb_state_t        state_nx;
    owner_t            owner;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              grant_d;
    logic              grant_if;
    logic              grant_en;
    logic              in_access;
    logic              last_cycle;
    logic              capture;

    assign grant_en = (state == IDLE);

    mem_arb_select #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_sel (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .d_req    (d_req),
        .grant_en (grant_en),
        .grant_d  (grant_d),
        .grant_if (grant_if)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (grant_d || grant_if) state_nx = ACCESS;
            ACCESS:  if (cnt == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner   <= OWN_IF;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if (grant_d) begin
            owner   <= OWN_D;
            cnt     <= CNT_W'(WAIT_STATES);
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            we_q    <= d_we;
        end else if (grant_if) begin
            owner   <= OWN_IF;
            cnt     <= CNT_W'(WAIT_STATES);
            addr_q  <= if_addr;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if (in_access && !last_cycle) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign in_access  = (state == ACCESS);
    assign last_cycle = (cnt == '0);
    assign capture    = in_access && last_cycle && !we_q;

    // Stores never touch d_rdata; fetches keep their word until the next one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_rdata <= '0;
            d_rdata  <= '0;
        end else if (capture) begin
            unique case (owner)
                OWN_IF:  if_rdata <= mem_rdata;
                OWN_D:   d_rdata  <= mem_rdata;
                default: ;
            endcase
        end
    end

    // Strobes decode from state so an async reset drops them at once
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_read  = in_access && !we_q;
    assign mem_write = in_access && we_q;
    assign if_ready  = (state == DONE) && (owner == OWN_IF);
    assign d_ready   = (state == DONE) && (owner == OWN_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a cycle-count port model.
// Directed scenarios first, then random traffic, then a zero-wait instance.
module tb_mem_port_arbiter;

    localparam int WS   = 1;
    localparam int MAXS = 4;
    localparam int LAT  = WS + 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_read;
    logic        mem_write;
    logic        mem_fix_en = 1'b0;
    logic [31:0] mem_fix = '0;

    logic        z_if_req = 1'b0;
    logic [31:0] z_if_addr = '0;
    logic [31:0] z_if_rdata;
    logic        z_if_ready;
    logic        z_d_req = 1'b0;
    logic        z_d_we = 1'b0;
    logic [31:0] z_d_addr = '0;
    logic [31:0] z_d_wdata = '0;
    logic [31:0] z_d_rdata;
    logic        z_d_ready;
    logic [31:0] z_mem_addr;
    logic [31:0] z_mem_wdata;
    logic [31:0] z_mem_rdata;
    logic        z_mem_read;
    logic        z_mem_write;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return mem_fix_en ? mem_fix : hash(a);
    endfunction

    assign mem_rdata   = mem_fix_en ? mem_fix : hash(mem_addr);
    assign z_mem_rdata = hash(z_mem_addr);

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .WAIT_STATES(WS), .MAX_DATA_STREAK(MAXS)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .WAIT_STATES(0), .MAX_DATA_STREAK(MAXS)
    ) dut0 (
        .clk(clk), .reset(reset),
        .if_req(z_if_req), .if_addr(z_if_addr),
        .if_rdata(z_if_rdata), .if_ready(z_if_ready),
        .d_req(z_d_req), .d_we(z_d_we), .d_addr(z_d_addr), .d_wdata(z_d_wdata),
        .d_rdata(z_d_rdata), .d_ready(z_d_ready),
        .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
        .mem_read(z_mem_read), .mem_write(z_mem_write),
        .mem_rdata(z_mem_rdata)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got no event want one at cycle %0d", nm, cyc);
    endtask

    typedef struct {
        bit is_d;
        int cyc;
    } evt_t;

    evt_t        evq[$];
    bit          seq[$];
    logic [31:0] if_q[$];
    logic [31:0] d_q[$];
    logic [31:0] last_d = '0;

    int          free_at = 0;
    int          win_lo = -1;
    int          win_hi = -2;
    int          run = 0;
    bit          cur_wr = 1'b0;
    logic [31:0] cur_addr = '0;
    logic [31:0] cur_wdata = '0;
    bit          m_in_win;
    bit          m_gd;
    evt_t        m_e;

    // Port model: a grant occupies LAT+1 cycles; strobes in the middle
    always @(negedge clk) begin
        if (!reset) begin
            check("rst_data", if_rdata | d_rdata | mem_addr | mem_wdata, '0);
            check("rst_ctl", {28'd0, mem_read, mem_write, if_ready, d_ready}, '0);
            evq.delete();
            free_at = 0;
            win_lo  = -1;
            win_hi  = -2;
            run     = 0;
        end else begin
            m_in_win = (cyc >= win_lo) && (cyc <= win_hi);
            check("strobe_rd", mem_read, m_in_win && !cur_wr);
            check("strobe_wr", mem_write, m_in_win && cur_wr);
            if (m_in_win) begin
                check("mem_addr", mem_addr, cur_addr);
                if (cur_wr) check("mem_wdata", mem_wdata, cur_wdata);
            end
            check("dual_ready", if_ready & d_ready, '0);
            if (if_ready || d_ready) begin
                if (evq.size() == 0) begin
                    fail("unexpected_ready");
                end else begin
                    m_e = evq.pop_front();
                    check("ready_owner", d_ready, m_e.is_d);
                    check("ready_cycle", cyc, m_e.cyc);
                    seq.push_back(d_ready);
                end
                if (if_ready) begin
                    if (if_q.size() == 0) fail("if_q_empty");
                    else check("if_rdata", if_rdata, if_q.pop_front());
                end
                if (d_ready) begin
                    if (d_q.size() == 0) fail("d_q_empty");
                    else check("d_rdata", d_rdata, d_q.pop_front());
                end
            end
            if (evq.size() > 0 && evq[0].cyc < cyc) begin
                fail("missing_ready");
                void'(evq.pop_front());
            end
            if (cyc >= free_at && (if_req || d_req)) begin
                m_gd = d_req && (!if_req || run < MAXS);
                if (m_gd && if_req) run = (run < MAXS) ? run + 1 : run;
                else run = 0;
                cur_wr    = m_gd && d_we;
                cur_addr  = m_gd ? d_addr : if_addr;
                cur_wdata = d_wdata;
                win_lo    = cyc + 1;
                win_hi    = cyc + 1 + WS;
                free_at   = cyc + LAT + 1;
                m_e.is_d  = m_gd;
                m_e.cyc   = cyc + LAT;
                evq.push_back(m_e);
            end
        end
    end

    // Requester tasks start at posedge+1 and return at posedge+1 with req low
    task automatic do_fetch(input logic [31:0] a);
        int n = 0;
        if_req  = 1'b1;
        if_addr = a;
        if_q.push_back(exp_rd(a));
        do begin
            @(negedge clk);
            n++;
        end while (!if_ready && n < 40);
        if (!if_ready) fail("if_timeout");
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    task automatic do_data(input bit we, input logic [31:0] a,
                           input logic [31:0] wd);
        int n = 0;
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        if (!we) last_d = exp_rd(a);
        d_q.push_back(last_d);
        do begin
            @(negedge clk);
            n++;
        end while (!d_ready && n < 40);
        if (!d_ready) fail("d_timeout");
        @(posedge clk);
        #1;
        d_req = 1'b0;
    endtask

    bit pat [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    initial begin
        repeat (4) begin
            @(posedge clk);
            #1;
            if_req  = 1'($urandom);
            if_addr = $urandom;
            d_req   = 1'($urandom);
            d_we    = 1'($urandom);
            d_addr  = $urandom;
            d_wdata = $urandom;
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #1;

        mem_fix_en = 1'b1;
        mem_fix    = 32'h2008_001C;
        do_fetch(32'h0000_0010);
        mem_fix_en = 1'b0;

        fork
            do_data(1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
            do_fetch(32'h0000_0014);
        join

        seq.delete();
        fork
            repeat (8) do_data(1'b0, $urandom & 32'hFFFF_FFFC, '0);
            repeat (2) do_fetch($urandom & 32'hFFFF_FFFC);
        join
        check("starve_len", seq.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < seq.size()) check("starve_order", seq[i], pat[i]);
        end

        fork
            do_data(1'b0, 32'h0000_0080, '0);
            begin
                int n = 0;
                while (!mem_read && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                if (!mem_read) fail("rst_no_access");
                #2;
                reset = 1'b0;
                #1;
                check("rst_async_rd", mem_read, 1'b0);
                repeat (3) @(posedge clk);
                #3;
                reset = 1'b1;
            end
        join

        fork
            for (int k = 0; k < 30; k++) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
                do_fetch($urandom);
            end
            for (int k = 0; k < 30; k++) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
                do_data(1'($urandom), $urandom, $urandom);
            end
        join

        check("if_q_left", if_q.size(), 0);
        check("d_q_left", d_q.size(), 0);
        check("evq_left", evq.size(), 0);

        @(posedge clk);
        #1;
        z_if_req  = 1'b1;
        z_if_addr = 32'h0000_0100;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("z_read", z_mem_read, (i == 1 || i == 4));
            check("z_ready", z_if_ready, (i == 2 || i == 5));
            check("z_write", z_mem_write, 1'b0);
            if (i == 1) check("z_addr0", z_mem_addr, 32'h0000_0100);
            if (i == 4) check("z_addr1", z_mem_addr, 32'h0000_0204);
            if (i == 2) check("z_rdata0", z_if_rdata, hash(32'h0000_0100));
            if (i == 5) check("z_rdata1", z_if_rdata, hash(32'h0000_0204));
            @(posedge clk);
            #1;
            if (i == 2) z_if_addr = 32'h0000_0204;
            if (i == 5) z_if_req = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
